issue_scoreboard: RTL and testbench

- Sits directly downstream of the decode control unit, between decode and execute.
- Tracks in-flight scalar, vector and flag writes in a pending-bit scoreboard.
- Stalls decode on RAW/WAW hazards and holds the issued instruction's hazard fields in a decode/execute handshake register.
- The execute stage consumes the registered output; writeback ports retire pending bits.

---
 rtl/scoreboard_pkg.sv | 25 ++
 rtl/sb_pend_array.sv | 69 ++++++
 rtl/issue_scoreboard.sv | 174 +++++++++++++++++
 tb/tb_issue_scoreboard.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// ============================================================================
// Module : scoreboard_pkg
// Brief  : Shared widths, link-register index and the destination record
//          that is carried from decode into execute.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scoreboard_pkg;

  localparam int REG_IDX_W = 5;
  // Decode's 32'hFFFF link target truncates to this 5-bit index.
  localparam int LINK_REG  = 31;

  typedef struct packed {
    logic                 sw_en;
    logic [REG_IDX_W-1:0] sw_idx;
    logic                 vw_en;
    logic [REG_IDX_W-1:0] vw_idx;
    logic                 flag_wr;
  } sb_dest_t;

endpackage

`default_nettype wire

// File: rtl/sb_pend_array.sv
// ============================================================================
// Module : sb_pend_array
// Brief  : NUM-entry pending-bit vector. One set port (issue), one clear
//          port (writeback), one flush clear port, an optional bypass mask
//          (same-cycle writeback) and a two-source plus destination lookup.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sb_pend_array #(
  parameter int NUM   = 32,
  parameter int IDX_W = $clog2(NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             flush_en,
  input  logic [IDX_W-1:0] flush_idx,
  input  logic             byp_en,
  input  logic [IDX_W-1:0] byp_idx,
  input  logic [IDX_W-1:0] rd_a_idx,
  input  logic [IDX_W-1:0] rd_b_idx,
  input  logic [IDX_W-1:0] wr_idx,
  output logic             hit_a,
  output logic             hit_b,
  output logic             hit_w,
  output logic             any_eff,
  output logic             any_raw
);

  logic [NUM-1:0] pend;
  logic [NUM-1:0] pend_nxt;
  logic [NUM-1:0] byp_mask;
  logic [NUM-1:0] pend_eff;

  // Bits retiring this cycle are hidden from lookups when bypass is enabled.
  always_comb begin
    byp_mask = '0;
    if (byp_en) byp_mask[byp_idx] = 1'b1;
    pend_eff = pend & ~byp_mask;
  end

  // Next state: clears first, then the issue set, so a bypassed re-issue
  // of a retiring index leaves the bit set.
  always_comb begin
    pend_nxt = pend;
    if (clr_en)   pend_nxt[clr_idx]   = 1'b0;
    if (flush_en) pend_nxt[flush_idx] = 1'b0;
    if (set_en)   pend_nxt[set_idx]   = 1'b1;
  end

  // Pending-bit storage; reset discards writebacks in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  assign hit_a   = pend_eff[rd_a_idx];
  assign hit_b   = pend_eff[rd_b_idx];
  assign hit_w   = pend_eff[wr_idx];
  assign any_eff = |pend_eff;
  assign any_raw = |pend;

endmodule

`default_nettype wire

// File: rtl/issue_scoreboard.sv
// ============================================================================
// Module : issue_scoreboard
// Brief  : Decode-to-execute issue stage. Tracks pending scalar, vector and
//          flag writes, stalls on RAW/WAW/drain hazards and holds the issued
//          destination fields in a one-entry handshake register.
//          Optional macro SCOREBOARD_WB_BYPASS_EN: same-cycle writebacks
//          mask their pending bits during hazard and drain evaluation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module issue_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NUM_SREG = 32,
  parameter int NUM_VREG = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sr1_en,
  input  logic [REG_IDX_W-1:0] in_sr1_idx,
  input  logic                 in_sr2_en,
  input  logic [REG_IDX_W-1:0] in_sr2_idx,
  input  logic                 in_vr1_en,
  input  logic [REG_IDX_W-1:0] in_vr1_idx,
  input  logic                 in_vr2_en,
  input  logic [REG_IDX_W-1:0] in_vr2_idx,
  input  logic                 in_sw_en,
  input  logic [REG_IDX_W-1:0] in_sw_idx,
  input  logic                 in_vw_en,
  input  logic [REG_IDX_W-1:0] in_vw_idx,
  input  logic                 in_flag_rd,
  input  logic                 in_flag_wr,
  input  logic                 in_drain,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sw_en,
  output logic [REG_IDX_W-1:0] out_sw_idx,
  output logic                 out_vw_en,
  output logic [REG_IDX_W-1:0] out_vw_idx,
  output logic                 out_flag_wr,
  input  logic                 wb_s_en,
  input  logic [REG_IDX_W-1:0] wb_s_idx,
  input  logic                 wb_v_en,
  input  logic [REG_IDX_W-1:0] wb_v_idx,
  input  logic                 wb_flag,
  input  logic                 flush,
  output logic                 busy
);

  localparam int SIDX_W = $clog2(NUM_SREG);
  localparam int VIDX_W = $clog2(NUM_VREG);

  sb_dest_t out_q;
  logic     f_pend;
  logic     issue;
  logic     flush_held;
  logic     s_hit_a, s_hit_b, s_hit_w, s_any_eff, s_any_raw;
  logic     v_hit_a, v_hit_b, v_hit_w, v_any_eff, v_any_raw;
  logic     s_byp, v_byp, f_byp;
  logic     f_eff;
  logic     hazard;
  logic     drain_block;
  logic     slot_free;

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign s_byp = wb_s_en;
  assign v_byp = wb_v_en;
  assign f_byp = wb_flag;
`else
  assign s_byp = 1'b0;
  assign v_byp = 1'b0;
  assign f_byp = 1'b0;
`endif

  assign flush_held = flush && out_valid;
  assign issue      = in_valid && in_ready;

  sb_pend_array #(.NUM(NUM_SREG), .IDX_W(SIDX_W)) u_s_pend (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue && in_sw_en),
    .set_idx   (in_sw_idx[SIDX_W-1:0]),
    .clr_en    (wb_s_en),
    .clr_idx   (wb_s_idx[SIDX_W-1:0]),
    .flush_en  (flush_held && out_q.sw_en),
    .flush_idx (out_q.sw_idx[SIDX_W-1:0]),
    .byp_en    (s_byp),
    .byp_idx   (wb_s_idx[SIDX_W-1:0]),
    .rd_a_idx  (in_sr1_idx[SIDX_W-1:0]),
    .rd_b_idx  (in_sr2_idx[SIDX_W-1:0]),
    .wr_idx    (in_sw_idx[SIDX_W-1:0]),
    .hit_a     (s_hit_a),
    .hit_b     (s_hit_b),
    .hit_w     (s_hit_w),
    .any_eff   (s_any_eff),
    .any_raw   (s_any_raw)
  );

  sb_pend_array #(.NUM(NUM_VREG), .IDX_W(VIDX_W)) u_v_pend (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue && in_vw_en),
    .set_idx   (in_vw_idx[VIDX_W-1:0]),
    .clr_en    (wb_v_en),
    .clr_idx   (wb_v_idx[VIDX_W-1:0]),
    .flush_en  (flush_held && out_q.vw_en),
    .flush_idx (out_q.vw_idx[VIDX_W-1:0]),
    .byp_en    (v_byp),
    .byp_idx   (wb_v_idx[VIDX_W-1:0]),
    .rd_a_idx  (in_vr1_idx[VIDX_W-1:0]),
    .rd_b_idx  (in_vr2_idx[VIDX_W-1:0]),
    .wr_idx    (in_vw_idx[VIDX_W-1:0]),
    .hit_a     (v_hit_a),
    .hit_b     (v_hit_b),
    .hit_w     (v_hit_w),
    .any_eff   (v_any_eff),
    .any_raw   (v_any_raw)
  );

  assign f_eff = f_pend && !f_byp;

  // RAW on sources, WAW on destinations, and flag read/write collisions.
  always_comb begin
    hazard = (in_sr1_en && s_hit_a) || (in_sr2_en && s_hit_b) ||
             (in_sw_en  && s_hit_w) ||
             (in_vr1_en && v_hit_a) || (in_vr2_en && v_hit_b) ||
             (in_vw_en  && v_hit_w) ||
             ((in_flag_rd || in_flag_wr) && f_eff);
  end

  assign drain_block = in_drain && (s_any_eff || v_any_eff || f_eff || out_valid);
  assign slot_free   = !out_valid || out_ready;
  assign in_ready    = !rst && !flush && slot_free && !hazard && !drain_block;

  // Flag pending bit: issue sets; writeback or flush of the held writer clears.
  always_ff @(posedge clk) begin
    if (rst)                                    f_pend <= 1'b0;
    else if (issue && in_flag_wr)               f_pend <= 1'b1;
    else if (wb_flag || (flush_held && out_q.flag_wr)) f_pend <= 1'b0;
  end

  // Decode/execute handshake register; flush beats issue, issue beats handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid     <= 1'b1;
      out_q.sw_en   <= in_sw_en;
      out_q.sw_idx  <= in_sw_idx;
      out_q.vw_en   <= in_vw_en;
      out_q.vw_idx  <= in_vw_idx;
      out_q.flag_wr <= in_flag_wr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_sw_en   = out_q.sw_en;
  assign out_sw_idx  = out_q.sw_idx;
  assign out_vw_en   = out_q.vw_en;
  assign out_vw_idx  = out_q.vw_idx;
  assign out_flag_wr = out_q.flag_wr;

  assign busy = s_any_raw || v_any_raw || f_pend || out_valid;

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// ============================================================================
// Module : tb_issue_scoreboard
// Brief  : Directed self-checking bench for issue_scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic       in_sr1_en = 1'b0, in_sr2_en = 1'b0, in_vr1_en = 1'b0, in_vr2_en = 1'b0;
  logic [4:0] in_sr1_idx = '0, in_sr2_idx = '0, in_vr1_idx = '0, in_vr2_idx = '0;
  logic       in_sw_en = 1'b0, in_vw_en = 1'b0;
  logic [4:0] in_sw_idx = '0, in_vw_idx = '0;
  logic       in_flag_rd = 1'b0, in_flag_wr = 1'b0, in_drain = 1'b0;
  logic       out_valid, out_ready = 1'b1;
  logic       out_sw_en, out_vw_en, out_flag_wr;
  logic [4:0] out_sw_idx, out_vw_idx;
  logic       wb_s_en = 1'b0, wb_v_en = 1'b0, wb_flag = 1'b0;
  logic [4:0] wb_s_idx = '0, wb_v_idx = '0;
  logic       flush = 1'b0;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1_en(in_sr1_en), .in_sr1_idx(in_sr1_idx),
    .in_sr2_en(in_sr2_en), .in_sr2_idx(in_sr2_idx),
    .in_vr1_en(in_vr1_en), .in_vr1_idx(in_vr1_idx),
    .in_vr2_en(in_vr2_en), .in_vr2_idx(in_vr2_idx),
    .in_sw_en(in_sw_en), .in_sw_idx(in_sw_idx),
    .in_vw_en(in_vw_en), .in_vw_idx(in_vw_idx),
    .in_flag_rd(in_flag_rd), .in_flag_wr(in_flag_wr), .in_drain(in_drain),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sw_en(out_sw_en), .out_sw_idx(out_sw_idx),
    .out_vw_en(out_vw_en), .out_vw_idx(out_vw_idx), .out_flag_wr(out_flag_wr),
    .wb_s_en(wb_s_en), .wb_s_idx(wb_s_idx),
    .wb_v_en(wb_v_en), .wb_v_idx(wb_v_idx), .wb_flag(wb_flag),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sr1_en = 1'b0; in_sr2_en = 1'b0; in_vr1_en = 1'b0; in_vr2_en = 1'b0;
    in_sw_en = 1'b0; in_vw_en = 1'b0;
    in_flag_rd = 1'b0; in_flag_wr = 1'b0; in_drain = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    step(); step(); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    vectors++; if ({out_sw_en, out_sw_idx, out_vw_en, out_vw_idx, out_flag_wr} !== 13'd0) begin miscompares++; $display("FAIL reset_out_fields: got %h want 0", {out_sw_en, out_sw_idx, out_vw_en, out_vw_idx, out_flag_wr}); end
    rst = 1'b0; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; in_sw_en = 1'b1; in_sw_idx = 5'd3; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL addi_ready: got %b want 1", in_ready); end
    step(); idle(); #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_out_valid: got %b want 1", out_valid); end
    vectors++; if ({out_sw_en, out_sw_idx} !== {1'b1, 5'd3}) begin miscompares++; $display("FAIL addi_out_sw: got %b/%0d want 1/3", out_sw_en, out_sw_idx); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL addi_busy: got %b want 1", busy); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_handoff: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL addi_busy_pend: got %b want 1", busy); end
    wb_s_en = 1'b1; wb_s_idx = 5'd3; step(); wb_s_en = 1'b0; #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL addi_retire_busy: got %b want 0", busy); end
  endtask

  task automatic test_raw();
    in_valid = 1'b1; in_sw_en = 1'b1; in_sw_idx = 5'd3;
    step(); idle();
    in_valid = 1'b1; in_sr1_en = 1'b1; in_sr1_idx = 5'd3; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall0: got %b want 0", in_ready); end
    step();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall1: got %b want 0", in_ready); end
    wb_s_en = 1'b1; wb_s_idx = 5'd3; #1;
    vectors++; if (in_ready !== BYP) begin miscompares++; $display("FAIL raw_wb_cycle_ready: got %b want %b", in_ready, BYP); end
    step(); wb_s_en = 1'b0; in_valid = !BYP; #1;
    vectors++; if (out_valid !== BYP) begin miscompares++; $display("FAIL raw_issue_in_wb: got %b want %b", out_valid, BYP); end
    step(); idle(); #1;
    vectors++; if (out_valid !== !BYP) begin miscompares++; $display("FAIL raw_issue_after_wb: got %b want %b", out_valid, !BYP); end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL raw_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_flag();
    in_valid = 1'b1; in_flag_wr = 1'b1;
    step(); idle();
    in_flag_rd = 1'b1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flag_branch_stall: got %b want 0", in_ready); end
    in_flag_rd = 1'b0; in_flag_wr = 1'b1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flag_waw_stall: got %b want 0", in_ready); end
    step();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flag_waw_stall2: got %b want 0", in_ready); end
    idle(); wb_flag = 1'b1; step(); wb_flag = 1'b0;
    in_valid = 1'b1; in_flag_rd = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flag_branch_go: got %b want 1", in_ready); end
    step(); idle(); #1;
    vectors++; if ({out_valid, out_flag_wr} !== 2'b10) begin miscompares++; $display("FAIL flag_branch_out: got %b want 10", {out_valid, out_flag_wr}); end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flag_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_dual();
    in_valid = 1'b1; in_sw_en = 1'b1; in_sw_idx = 5'd5; in_vw_en = 1'b1; in_vw_idx = 5'd7;
    step(); idle(); #1;
    vectors++; if ({out_sw_en, out_sw_idx, out_vw_en, out_vw_idx} !== {1'b1, 5'd5, 1'b1, 5'd7}) begin miscompares++; $display("FAIL dual_out: got %b/%0d %b/%0d want 1/5 1/7", out_sw_en, out_sw_idx, out_vw_en, out_vw_idx); end
    step();
    in_vr2_en = 1'b1; in_vr2_idx = 5'd7; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL dual_v7_stall: got %b want 0", in_ready); end
    in_vr2_en = 1'b0; in_sr2_en = 1'b1; in_sr2_idx = 5'd5; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL dual_s5_stall: got %b want 0", in_ready); end
    wb_v_en = 1'b1; wb_v_idx = 5'd7; step(); wb_v_en = 1'b0;
    in_sr2_en = 1'b0; in_vr2_en = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL dual_v7_go: got %b want 1", in_ready); end
    in_vr2_en = 1'b0; in_sr2_en = 1'b1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL dual_s5_still: got %b want 0", in_ready); end
    wb_s_en = 1'b1; wb_s_idx = 5'd5; step(); wb_s_en = 1'b0; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL dual_s5_go: got %b want 1", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL dual_end_busy: got %b want 0", busy); end
    idle();
  endtask

  task automatic test_backpressure_flush();
    in_valid = 1'b1; in_sw_en = 1'b1; in_sw_idx = 5'd4;
    step(); idle(); step();
    out_ready = 1'b0; in_valid = 1'b1; in_vw_en = 1'b1; in_vw_idx = 5'd2; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_v2_issue: got %b want 1", in_ready); end
    step(); idle();
    in_valid = 1'b1; in_sw_en = 1'b1; in_sw_idx = 5'd10;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready cyc%0d: got %b want 0", i, in_ready); end
      vectors++; if ({out_valid, out_vw_en, out_vw_idx, out_sw_en} !== {1'b1, 1'b1, 5'd2, 1'b0}) begin miscompares++; $display("FAIL bp_hold cyc%0d: got %b%b/%0d/%b want 11/2/0", i, out_valid, out_vw_en, out_vw_idx, out_sw_en); end
      step();
    end
    flush = 1'b1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    step(); flush = 1'b0; idle(); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    in_vr1_en = 1'b1; in_vr1_idx = 5'd2; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_v2_cleared: got %b want 1", in_ready); end
    in_vr1_en = 1'b0; in_sr1_en = 1'b1; in_sr1_idx = 5'd4; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_s4_kept: got %b want 0", in_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL flush_busy: got %b want 1", busy); end
    idle(); out_ready = 1'b1;
    wb_s_en = 1'b1; wb_s_idx = 5'd4; step(); wb_s_en = 1'b0; #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_drain();
    in_valid = 1'b1; in_sw_en = 1'b1; in_sw_idx = 5'd9;
    step(); idle();
    in_drain = 1'b1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL drain_outvalid_stall: got %b want 0", in_ready); end
    step();
    vectors++; if ({out_valid, in_ready} !== 2'b00) begin miscompares++; $display("FAIL drain_pend_stall: got %b want 00", {out_valid, in_ready}); end
    in_valid = 1'b1; wb_s_en = 1'b1; wb_s_idx = 5'd9; #1;
    vectors++; if (in_ready !== BYP) begin miscompares++; $display("FAIL drain_wb_cycle_ready: got %b want %b", in_ready, BYP); end
    step(); wb_s_en = 1'b0; in_valid = !BYP; #1;
    vectors++; if (out_valid !== BYP) begin miscompares++; $display("FAIL drain_issue_in_wb: got %b want %b", out_valid, BYP); end
    step(); idle(); #1;
    vectors++; if (out_valid !== !BYP) begin miscompares++; $display("FAIL drain_issue_after_wb: got %b want %b", out_valid, !BYP); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sw_en = 1'b1; in_sw_idx = 5'(11 + i); #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
      step();
      vectors++; if ({out_valid, out_sw_idx} !== {1'b1, 5'(11 + i)}) begin miscompares++; $display("FAIL b2b_out%0d: got %b/%0d want 1/%0d", i, out_valid, out_sw_idx, 11 + i); end
    end
    idle(); step();
    for (int i = 0; i < 3; i++) begin
      wb_s_en = 1'b1; wb_s_idx = 5'(11 + i); step();
    end
    wb_s_en = 1'b0; #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_link_reset_mid();
    in_valid = 1'b1; in_sw_en = 1'b1; in_sw_idx = 5'd31;
    step(); idle();
    in_sr1_en = 1'b1; in_sr1_idx = 5'd31; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL link_stall: got %b want 0", in_ready); end
    rst = 1'b1; wb_s_en = 1'b1; wb_s_idx = 5'd31;
    step(); rst = 1'b0; wb_s_en = 1'b0; #1;
    vectors++; if ({out_valid, out_sw_en, out_sw_idx, busy} !== 8'd0) begin miscompares++; $display("FAIL midrst_state: got %b want 0", {out_valid, out_sw_en, out_sw_idx, busy}); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_link_free: got %b want 1", in_ready); end
    idle();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_raw();
    test_flag();
    test_dual();
    test_backpressure_flush();
    test_drain();
    test_back_to_back();
    test_link_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
